pe_shift_accumulator: RTL and testbench
=======================================

Name: pe_shift_accumulator

Overview:
- Sits directly downstream of the PE shift stage.
- Sign-extends and sums the stream of shifted PE partial sums (one per bit-brick weight/activation combination) into a per-group result.
- Emits the result over a valid/ready handshake to the output/writeback stage.
- A group is delimited by in_last; groups are back-to-back with no idle cycle required.

Parameters:
- IN_W, 20, width of the signed shifted partial sum from the shift stage.
- ACC_W, 24, accumulator/result width (signed two's complement); must be >= IN_W.
- MAX_TERMS, 16, maximum beats per group; the MAX_TERMS-th beat force-closes the group.
- CNT_W, 5, term-counter width; must hold MAX_TERMS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  IN_W  signed shifted partial sum.
- in_last  in  1  final beat of the current group.
- out_valid  out  1  out_data/out_terms hold a completed group.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  signed group sum.
- out_terms  out  CNT_W  number of beats summed into out_data.
- out_sat  out  1  group result clamped (0 when SATURATE_EN undefined).
- err_len  out  1  sticky: a group was force-closed at MAX_TERMS.

Behaviour:
- Reset (reset=0, asynchronous) clears to zero:
  - outputs: out_valid, out_data, out_terms, out_sat, err_len;
  - internal: acc, cnt;
  - state goes to IDLE.
- Reset asserted mid-group discards the partial group and any undelivered result.
- Accept: a beat is accepted on a rising edge when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready and permits accepting a closing beat in the same cycle the previous result drains.
- Arithmetic:
  - sum = base + sext(in_data, ACC_W).
  - base is 0 in IDLE, acc in ACC.
- State machine:
  - IDLE: no partial group. An accepted beat with in_last=0 → ACC, acc<=sum, cnt<=1. An accepted beat with in_last=1 closes immediately (single-term group).
  - ACC: an accepted beat with in_last=0 and cnt+1 < MAX_TERMS → acc<=sum, cnt<=cnt+1.
  - Close condition: an accepted beat with in_last=1, OR cnt+1 == MAX_TERMS.
- Close (from either state):
  - out_data<=sum, out_terms<=cnt+1 (1 from IDLE), out_valid<=1.
  - acc<=0, cnt<=0, state → IDLE.
  - If closed by MAX_TERMS with in_last=0: err_len<=1 (sticky until reset). Following beats start a new group.
- Output: out_valid clears on out_valid && out_ready unless a new close occurs in the same cycle, in which case the output register reloads and out_valid stays 1.
- Latency: out_valid rises on the clock edge that accepts the closing beat, i.e. it is visible one cycle after the beat is presented.
- Backpressure: while out_valid && !out_ready, in_ready=0 and acc/cnt hold.
- in_data is ignored when in_valid=0.
- Overflow without SATURATE_EN wraps modulo 2^ACC_W.

Optional Feature:
- Macro: PE_ACC_SATURATE_EN.
- Defined:
  - Every accumulation step clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A clamp on any step of a group sets out_sat with that group's result.
  - The per-group clamp flag resets on close.
- Undefined: the block wraps on overflow, has no clamp logic, and ties out_sat to 0.

Decomposition:
- Package pe_acc_pkg holds:
  - IN_W/ACC_W/MAX_TERMS/CNT_W defaults;
  - state enum {IDLE, ACC};
  - sign-extend function;
  - ACC_MAX/ACC_MIN constants.
- One sub-module: pe_acc_add, a combinational sign-extending adder with an optional clamp and a sat flag output (clamp logic only under PE_ACC_SATURATE_EN).

Test Plan:
- Four beats +9, -2, +4096, -4096 (last on 4th), out_ready=1 → out_data=7, out_terms=4, out_valid exactly one cycle after the 4th beat.
- Single beat in_data=20'hFFFFE (−2), in_last=1 → out_data=24'hFFFFFE, out_terms=1.
- out_ready=0 after a result: in_ready=0 and data held. Raise out_ready in the same cycle as the closing beat of the next group → both results delivered, none lost.
- 16 beats of +1, never last → out_data=16, out_terms=16, err_len=1. The 17th beat starts a new group with out_terms=1.
- With PE_ACC_SATURATE_EN, ACC_W=20: beats 20'h7FFFF, +1, last → out_data=20'h7FFFF, out_sat=1. Without the macro, the same beats give out_data=20'h80000, out_sat=0.
- Assert reset after two beats of a group, then release and send +3, last → out_data=3, out_terms=1.

Source files
------------

// File: rtl/pe_acc_pkg.sv
// Shared defaults, FSM state type and sign-extension helper for the PE shift accumulator.
// Clamp constants are consumed only when PE_ACC_SATURATE_EN is defined.
package pe_acc_pkg;

    localparam int IN_W_DEF      = 20;
    localparam int ACC_W_DEF     = 24;
    localparam int MAX_TERMS_DEF = 16;
    localparam int CNT_W_DEF     = 5;

    // Working width for the saturating add; comfortably wider than any accumulator.
    localparam int SEXT_W = 64;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    // Treats bit w-1 of v as the sign and replicates it through the full SEXT_W bits.
    function automatic logic [SEXT_W-1:0] sign_extend(input logic [SEXT_W-1:0] v,
                                                      input int unsigned w);
        return SEXT_W'($signed(v << (SEXT_W - w)) >>> (SEXT_W - w));
    endfunction

endpackage

// File: rtl/pe_acc_add.sv
// Combinational sign-extending adder: sum = base + sext(in_data).
// Clamping to the signed ACC_W range is compiled in only under PE_ACC_SATURATE_EN.
module pe_acc_add
    import pe_acc_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] base,
    input  logic [IN_W-1:0]  in_data,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

`ifdef PE_ACC_SATURATE_EN
    logic signed [SEXT_W-1:0] wide;
    logic signed [SEXT_W-1:0] max_w;
    logic signed [SEXT_W-1:0] min_w;

    assign wide  = $signed(sign_extend(SEXT_W'(in_data), IN_W))
                 + $signed(sign_extend(SEXT_W'(base), ACC_W));
    assign max_w = $signed((SEXT_W'(1) << (ACC_W - 1)) - SEXT_W'(1));
    assign min_w = ~max_w;

    always_comb begin
        sum = wide[ACC_W-1:0];
        sat = 1'b0;
        if (wide > max_w) begin
            sum = max_w[ACC_W-1:0];
            sat = 1'b1;
        end else if (wide < min_w) begin
            sum = min_w[ACC_W-1:0];
            sat = 1'b1;
        end
    end
`else
    assign sum = base + ACC_W'($signed(in_data));
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/pe_shift_accumulator.sv
// Sums a group of signed shifted PE partial sums (delimited by in_last or MAX_TERMS) into one result.
// Optional saturation is enabled with the PE_ACC_SATURATE_EN macro; otherwise the sum wraps and out_sat is 0.
module pe_shift_accumulator
    import pe_acc_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_terms,
    output logic             out_sat,
    output logic             err_len
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_terms_q, out_terms_d;
    logic               err_len_q, err_len_d;

    logic [ACC_W-1:0]   base;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic               add_sat;
    logic               accept;
    logic               close;

    // A closing beat may land in the same cycle the previous result drains.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign base     = (state_q == ACC) ? acc_q : '0;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign close    = accept && (in_last || (cnt_inc == CNT_W'(MAX_TERMS)));

    pe_acc_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .base    (base),
        .in_data (in_data),
        .sum     (sum),
        .sat     (add_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_terms_d = out_terms_q;
        err_len_d   = err_len_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (close) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_terms_d = cnt_inc;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = IDLE;
            if (!in_last) begin
                err_len_d = 1'b1;
            end
        end else if (accept) begin
            acc_d   = sum;
            cnt_d   = cnt_inc;
            state_d = ACC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_terms_q <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_terms_q <= out_terms_d;
            err_len_q   <= err_len_d;
        end
    end

`ifdef PE_ACC_SATURATE_EN
    logic sat_grp_q, sat_grp_d;
    logic out_sat_q, out_sat_d;

    // Any clamped step marks the whole group; the mark moves to out_sat on close.
    always_comb begin
        sat_grp_d = sat_grp_q;
        out_sat_d = out_sat_q;
        if (close) begin
            out_sat_d = sat_grp_q || add_sat;
            sat_grp_d = 1'b0;
        end else if (accept) begin
            sat_grp_d = sat_grp_q || add_sat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_grp_q <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_grp_q <= sat_grp_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_sat = out_sat_q;
`else
    // The adder holds sat low when clamping is compiled out.
    assign out_sat = add_sat;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_terms = out_terms_q;
    assign err_len   = err_len_q;

endmodule

// File: tb/tb_pe_shift_accumulator.sv
// Self-checking bench for pe_shift_accumulator: integer group model checked every cycle plus literal expectations.
// A second instance with ACC_W=20 exercises overflow (wrap, or clamp under PE_ACC_SATURATE_EN).
module tb_pe_shift_accumulator;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [4:0]  out_terms;
    logic        out_sat;
    logic        err_len;

    logic        in_valid2;
    logic        in_ready2;
    logic [19:0] in_data2;
    logic        in_last2;
    logic        out_valid2;
    logic        out_ready2;
    logic [19:0] out_data2;
    logic [4:0]  out_terms2;
    logic        out_sat2;
    logic        err_len2;

    int tests = 0;
    int fails = 0;

    logic [23:0] delivered[$];

    pe_shift_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_terms (out_terms),
        .out_sat   (out_sat),
        .err_len   (err_len)
    );

    pe_shift_accumulator #(
        .IN_W      (20),
        .ACC_W     (20),
        .MAX_TERMS (16),
        .CNT_W     (5)
    ) dut20 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .in_last   (in_last2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .out_terms (out_terms2),
        .out_sat   (out_sat2),
        .err_len   (err_len2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one beat right after a rising edge, holds it across the next edge, then drops it.
    task automatic applyStimulus(input int sel, input logic [19:0] d, input logic l);
        if (sel == 0) begin
            in_valid = 1'b1;
            in_data  = d;
            in_last  = l;
        end else begin
            in_valid2 = 1'b1;
            in_data2  = d;
            in_last2  = l;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
    endtask

    // Group-level reference: integer running sum, beat count, wrap by masking on output.
    localparam longint MAX24 = 64'sd8388607;
    localparam longint MIN24 = -64'sd8388608;

    longint      g_sum;
    int          g_n;
    bit          g_sat;
    bit          m_valid;
    bit          m_err;
    bit          m_sat;
    logic [23:0] m_data;
    int          m_terms;

    always @(posedge clk or negedge reset) begin : model
        longint s;
        int     n;
        bit     st;
        if (!reset) begin
            g_sum   <= 0;
            g_n     <= 0;
            g_sat   <= 1'b0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_sat   <= 1'b0;
            m_data  <= '0;
            m_terms <= 0;
        end else begin
            s  = g_sum;
            n  = g_n;
            st = g_sat;
            if (m_valid && out_ready) m_valid <= 1'b0;
            if (in_valid && (!m_valid || out_ready)) begin
                s = s + longint'($signed(in_data));
                n = n + 1;
`ifdef PE_ACC_SATURATE_EN
                if (s > MAX24) begin
                    s  = MAX24;
                    st = 1'b1;
                end else if (s < MIN24) begin
                    s  = MIN24;
                    st = 1'b1;
                end
`endif
                if (in_last || n == 16) begin
                    m_valid <= 1'b1;
                    m_data  <= s[23:0];
                    m_terms <= n;
                    m_sat   <= st;
                    if (!in_last) m_err <= 1'b1;
                    s  = 0;
                    n  = 0;
                    st = 1'b0;
                end
            end
            g_sum <= s;
            g_n   <= n;
            g_sat <= st;
        end
    end

    always @(posedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            delivered.push_back(out_data);
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checkOutput("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("cyc_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            checkOutput("cyc_err_len", 32'(err_len), 32'(m_err));
            checkOutput("cyc_out_sat", 32'(out_sat), 32'(m_sat));
            if (m_valid) begin
                checkOutput("cyc_out_data", 32'(out_data), 32'(m_data));
                checkOutput("cyc_out_terms", 32'(out_terms), 32'(m_terms));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_idx;

        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = '0;
        in_last2   = 1'b0;
        out_ready2 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_terms", 32'(out_terms), 32'd0);
        checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
        checkOutput("rst_err_len", 32'(err_len), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Four-beat group summing to 7.
        applyStimulus(0, 20'd9, 1'b0);
        applyStimulus(0, 20'hFFFFE, 1'b0);
        applyStimulus(0, 20'h01000, 1'b0);
        checkOutput("grp4_not_yet_valid", 32'(out_valid), 32'd0);
        applyStimulus(0, 20'hFF000, 1'b1);
        checkOutput("grp4_valid", 32'(out_valid), 32'd1);
        checkOutput("grp4_data", 32'(out_data), 32'd7);
        checkOutput("grp4_terms", 32'(out_terms), 32'd4);
        @(posedge clk);
        #1;

        // Single-term negative group.
        applyStimulus(0, 20'hFFFFE, 1'b1);
        checkOutput("single_data", 32'(out_data), 32'h00FFFFFE);
        checkOutput("single_terms", 32'(out_terms), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure, then drain and close in the same cycle.
        base_idx  = delivered.size();
        out_ready = 1'b0;
        applyStimulus(0, 20'd5, 1'b1);
        checkOutput("bp_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_data", 32'(out_data), 32'd5);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bp_hold_data", 32'(out_data), 32'd5);
        in_valid = 1'b1;
        in_data  = 20'd6;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_blocked_data", 32'(out_data), 32'd5);
        checkOutput("bp_blocked_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_reload_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_reload_data", 32'(out_data), 32'd6);
        checkOutput("bp_reload_terms", 32'(out_terms), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp_delivered_cnt", 32'(delivered.size() - base_idx), 32'd2);
        if (delivered.size() - base_idx == 2) begin
            checkOutput("bp_first_out", 32'(delivered[base_idx]), 32'd5);
            checkOutput("bp_second_out", 32'(delivered[base_idx+1]), 32'd6);
        end

        // Sixteen beats with no in_last force-close the group.
        for (int i = 0; i < 15; i++) applyStimulus(0, 20'd1, 1'b0);
        checkOutput("max_not_yet_valid", 32'(out_valid), 32'd0);
        applyStimulus(0, 20'd1, 1'b0);
        checkOutput("max_valid", 32'(out_valid), 32'd1);
        checkOutput("max_data", 32'(out_data), 32'd16);
        checkOutput("max_terms", 32'(out_terms), 32'd16);
        checkOutput("max_err_len", 32'(err_len), 32'd1);
        applyStimulus(0, 20'd1, 1'b1);
        checkOutput("after_max_terms", 32'(out_terms), 32'd1);
        checkOutput("after_max_data", 32'(out_data), 32'd1);
        checkOutput("after_max_err_sticky", 32'(err_len), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a group drops the partial sum.
        applyStimulus(0, 20'd100, 1'b0);
        applyStimulus(0, 20'd200, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_err_len", 32'(err_len), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 20'd3, 1'b1);
        checkOutput("midrst_data", 32'(out_data), 32'd3);
        checkOutput("midrst_terms", 32'(out_terms), 32'd1);
        @(posedge clk);
        #1;

        // Overflow on the 20-bit accumulator instance.
        applyStimulus(1, 20'h7FFFF, 1'b0);
        applyStimulus(1, 20'd1, 1'b1);
        checkOutput("ovf_valid", 32'(out_valid2), 32'd1);
        checkOutput("ovf_terms", 32'(out_terms2), 32'd2);
`ifdef PE_ACC_SATURATE_EN
        checkOutput("ovf_data", 32'(out_data2), 32'h7FFFF);
        checkOutput("ovf_sat", 32'(out_sat2), 32'd1);
`else
        checkOutput("ovf_data", 32'(out_data2), 32'h80000);
        checkOutput("ovf_sat", 32'(out_sat2), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
